// File: rtl/mem_bist_master.sv
// Self-test master for the memory valid/ready port: writes a pattern over an
// address window, reads it back and reports pass/fail, error count and first bad address.
module mem_bist_master #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  valid_o,
    output logic                  wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    localparam int unsigned LW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_e;

    // Pattern generator shared by write data and read-back comparison.
    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [1:0]            mode,
        input logic [DATA_WIDTH-1:0] seed
    );
        logic [DATA_WIDTH-1:0] rep;
        logic [DATA_WIDTH-1:0] alt;
        rep = '0;
        alt = '0;
        for (int i = 0; i < int'((DATA_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH); i++) begin
            rep = (rep << ADDR_WIDTH) | DATA_WIDTH'(a);
        end
        for (int i = 0; i < int'((DATA_WIDTH + 1) / 2); i++) begin
            alt = (alt << 2) | DATA_WIDTH'(2'b10);
        end
        case (mode)
            2'd0:    pattern = DATA_WIDTH'(a);
            2'd1:    pattern = a[0] ? ~alt : alt;
            2'd2:    pattern = ~DATA_WIDTH'(a);
            default: pattern = seed ^ rep;
        endcase
    endfunction

    state_e                state_q, state_d;
    logic [LW-1:0]         k_q, k_d;
    logic [LW-1:0]         len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  valid_q, valid_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [LW-1:0]         err_q, err_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;

    logic                  hs_c;
    logic                  last_c;
    logic [ADDR_WIDTH-1:0] next_addr_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            len_q   <= '0;
            base_q  <= '0;
            mode_q  <= '0;
            seed_q  <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        base_d  = base_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        valid_d = valid_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pass_d  = pass_q;
        err_d   = err_q;
        first_d = first_q;

        hs_c        = valid_q && ready_i;
        last_c      = (k_q == len_q - LW'(1));
        next_addr_c = addr_q + ADDR_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    base_d  = start_addr_i;
                    len_d   = length_i;
                    mode_d  = mode_i;
                    seed_d  = seed_i;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                    k_d     = '0;
                    if (length_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WRITE;
                        valid_d = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = start_addr_i;
                        wdata_d = pattern(start_addr_i, mode_i, seed_i);
                    end
                end
            end
            S_WRITE: begin
                if (hs_c) begin
                    if (last_c) begin
                        // Read phase starts immediately: no bubble on valid.
                        state_d = S_READ;
                        k_d     = '0;
                        wr_d    = 1'b0;
                        addr_d  = base_q;
                        wdata_d = '0;
                    end else begin
                        k_d     = k_q + LW'(1);
                        addr_d  = next_addr_c;
                        wdata_d = pattern(next_addr_c, mode_q, seed_q);
                    end
                end
            end
            S_READ: begin
                if (hs_c) begin
                    if (rdata_i != pattern(addr_q, mode_q, seed_q)) begin
                        if (err_q == '0) begin
                            first_d = addr_q;
                        end
                        if (err_q != '1) begin
                            err_d = err_q + LW'(1);
                        end
                    end
                    if (last_c) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        addr_d  = '0;
                    end else begin
                        k_d    = k_q + LW'(1);
                        addr_d = next_addr_c;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_DONE) begin
            pass_d = (err_d == '0);
        end
        busy_d = (state_d == S_WRITE) || (state_d == S_READ);
        done_d = (state_d == S_DONE);
    end

    assign valid_o          = valid_q;
    assign wr_rd_en_o       = wr_q;
    assign addr_o           = addr_q;
    assign w_data_o         = wdata_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Scoreboard bench for mem_bist_master: ideal memory with fault injection and ready stalls.
module tb_mem_bist_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  start_addr_i;
    logic [4:0]  length_i;
    logic [1:0]  mode_i;
    logic [15:0] seed_i;
    logic        valid_o;
    logic        wr_rd_en_o;
    logic [3:0]  addr_o;
    logic [15:0] w_data_o;
    logic        ready_i;
    logic [15:0] rdata_i;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [4:0]  err_count_o;
    logic [3:0]  first_err_addr_o;

    mem_bist_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .start_addr_i     (start_addr_i),
        .length_i         (length_i),
        .mode_i           (mode_i),
        .seed_i           (seed_i),
        .valid_o          (valid_o),
        .wr_rd_en_o       (wr_rd_en_o),
        .addr_o           (addr_o),
        .w_data_o         (w_data_o),
        .ready_i          (ready_i),
        .rdata_i          (rdata_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .pass_o           (pass_o),
        .err_count_o      (err_count_o),
        .first_err_addr_o (first_err_addr_o)
    );

    always #5 clk = ~clk;

    // Ideal memory; addresses flagged in fault_mask read back as all-ones.
    logic [15:0] mem [16];
    logic [15:0] fault_mask;

    always @(posedge clk) begin
        if (valid_o && ready_i && wr_rd_en_o) mem[addr_o] <= w_data_o;
    end
    assign rdata_i = (!wr_rd_en_o && fault_mask[addr_o]) ? 16'hFFFF : mem[addr_o];

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
    } req_t;

    req_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic ready_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [3:0] a, input logic [1:0] mode, input logic [15:0] seed);
        case (mode)
            2'd0:    return {12'h000, a};
            2'd1:    return a[0] ? 16'h5555 : 16'hAAAA;
            2'd2:    return ~{12'h000, a};
            default: return seed ^ {a, a, a, a};
        endcase
    endfunction

    task automatic run_test(input logic [3:0] sa, input logic [4:0] len, input logic [1:0] mode,
                            input logic [15:0] seed, input int rpat, input int abort_k, input bit poke);
        int          errs = 0;
        logic [3:0]  ferr = '0;
        int          cyc;
        int          rd_seen = 0;
        bit          stalled = 0;
        logic [3:0]  a;
        logic [3:0]  p_addr = '0;
        logic [15:0] p_data = '0;
        logic        p_wr = 1'b0;
        req_t        e;
        for (int k = 0; k < int'(len); k++) begin
            a = sa + 4'(k);
            exp_q.push_back('{wr: 1'b1, addr: a, data: pat(a, mode, seed)});
        end
        for (int k = 0; k < int'(len); k++) begin
            a = sa + 4'(k);
            exp_q.push_back('{wr: 1'b0, addr: a, data: 16'h0000});
            if (fault_mask[a] && pat(a, mode, seed) != 16'hFFFF) begin
                if (errs == 0) ferr = a;
                errs++;
            end
        end
        @(negedge clk);
        start_i = 1'b1; start_addr_i = sa; length_i = len; mode_i = mode; seed_i = seed;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        while (cyc <= 200 && !done_o) begin
            if (stalled) begin
                check_eq("stall_addr", 32'(addr_o), 32'(p_addr));
                check_eq("stall_data", 32'(w_data_o), 32'(p_data));
                check_eq("stall_wr", 32'(wr_rd_en_o), 32'(p_wr));
                check_eq("stall_valid", 32'(valid_o), 32'd1);
            end
            if (valid_o) check_eq("busy_run", 32'(busy_o), 32'd1);
            ready_i = (rpat == 0) ? 1'b1 : ready_tab[cyc % 4];
            if (poke && cyc == 3) begin
                start_i = 1'b1; start_addr_i = ~sa; length_i = 5'd0;
            end else begin
                start_i = 1'b0;
            end
            if (valid_o && ready_i) begin
                if (abort_k >= 0 && !wr_rd_en_o && rd_seen == abort_k) begin
                    rst_i = 1'b1;
                    @(negedge clk);
                    rst_i = 1'b0;
                    check_eq("abort_valid", 32'(valid_o), 32'd0);
                    check_eq("abort_busy", 32'(busy_o), 32'd0);
                    check_eq("abort_addr", 32'(addr_o), 32'd0);
                    check_eq("abort_wr", 32'(wr_rd_en_o), 32'd0);
                    check_eq("abort_err", 32'(err_count_o), 32'd0);
                    for (int i = 0; i < 3; i++) begin
                        check_eq("abort_no_done", 32'(done_o), 32'd0);
                        @(negedge clk);
                    end
                    exp_q.delete();
                    return;
                end
                check_eq("req_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("req_wr", 32'(wr_rd_en_o), 32'(e.wr));
                    check_eq("req_addr", 32'(addr_o), 32'(e.addr));
                    check_eq("req_data", 32'(w_data_o), 32'(e.data));
                end
                if (!wr_rd_en_o) rd_seen++;
                stalled = 0;
            end else begin
                stalled = valid_o;
            end
            p_addr = addr_o; p_data = w_data_o; p_wr = wr_rd_en_o;
            @(negedge clk);
            cyc++;
        end
        start_i = 1'b0;
        check_eq("done_seen", 32'(done_o), 32'd1);
        if (rpat == 0) check_eq("latency", 32'(cyc), 32'(2 * int'(len) + 1));
        check_eq("busy_done", 32'(busy_o), 32'd0);
        check_eq("valid_done", 32'(valid_o), 32'd0);
        check_eq("pass", 32'(pass_o), 32'(errs == 0));
        check_eq("err_count", 32'(err_count_o), 32'(errs));
        check_eq("first_err", 32'(first_err_addr_o), 32'(ferr));
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        check_eq("done_pulse", 32'(done_o), 32'd0);
        check_eq("pass_hold", 32'(pass_o), 32'(errs == 0));
    endtask

    initial begin
        int pulses;
        rst_i = 1'b1; start_i = 1'b0; start_addr_i = '0; length_i = '0;
        mode_i = '0; seed_i = '0; ready_i = 1'b1; fault_mask = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_wr", 32'(wr_rd_en_o), 32'd0);
        check_eq("rst_addr", 32'(addr_o), 32'd0);
        check_eq("rst_wdata", 32'(w_data_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_pass", 32'(pass_o), 32'd0);
        check_eq("rst_err", 32'(err_count_o), 32'd0);
        check_eq("rst_first", 32'(first_err_addr_o), 32'd0);
        rst_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (valid_o || busy_o || done_o) pulses++;
        end
        check_eq("idle_activity", 32'(pulses), 32'd0);

        run_test(4'd0, 5'd16, 2'd0, 16'h0000, 0, -1, 1'b0);
        run_test(4'd14, 5'd4, 2'd1, 16'h0000, 0, -1, 1'b0);
        run_test(4'd5, 5'd10, 2'd2, 16'h0000, 1, -1, 1'b0);
        fault_mask = 16'h0088;
        run_test(4'd0, 5'd8, 2'd0, 16'h0000, 0, -1, 1'b0);
        fault_mask = 16'h0000;
        run_test(4'd9, 5'd16, 2'd3, 16'hC3A5, 1, -1, 1'b1);
        run_test(4'd7, 5'd0, 2'd0, 16'h0000, 0, -1, 1'b0);
        run_test(4'd2, 5'd12, 2'd2, 16'h0000, 0, 5, 1'b0);
        run_test(4'd0, 5'd16, 2'd0, 16'h0000, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
